// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: serial pattern detector with a run controller.
// A run is armed by start, counts (overlapping) pattern hits on the
// qualified serial stream and finishes when the configured hit count
// is reached. Configuration is captured into shadow registers in IDLE only.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [MAX_LEN-1:0]        cfg_pattern,
  input  logic [$clog2(MAX_LEN):0]  cfg_len,
  input  logic [CNT_W-1:0]          cfg_max_hits,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      data_valid,
  input  logic                      data_in,
  output logic                      busy,
  output logic                      match,
  output logic [CNT_W-1:0]          hit_count,
  output logic                      done,
  output logic                      cfg_err
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Mask selecting the low 'len' bits of a MAX_LEN-wide window.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  state_t               state_r;
  logic                 rst_meta_r;
  logic                 rst_sync_r;
  logic [MAX_LEN-1:0]   pattern_r;
  logic [LEN_W-1:0]     len_r;
  logic [CNT_W-1:0]     max_hits_r;
  logic [MAX_LEN-2:0]   history_r;
  logic [LEN_W-1:0]     fill_r;
  logic [CNT_W-1:0]     hit_count_r;
  logic                 busy_r;
  logic                 match_r;
  logic                 done_r;
  logic                 cfg_err_r;

  logic [MAX_LEN-1:0]   window_s;
  logic [MAX_LEN-1:0]   mask_s;
  logic                 fill_ok_s;
  logic                 hit_s;
  logic                 last_hit_s;
  logic                 cfg_ok_s;

  // Reset release synchronizer: asserts immediately, releases after two clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Hit detection on the window formed by history plus the incoming bit.
  always_comb begin
    window_s   = {history_r, data_in};
    mask_s     = len_mask(len_r);
    fill_ok_s  = (({1'b0, fill_r} + (LEN_W+1)'(1)) >= {1'b0, len_r});
    hit_s      = (state_r == RUN) && data_valid && fill_ok_s &&
                 ((window_s & mask_s) == (pattern_r & mask_s));
    last_hit_s = hit_s && ((hit_count_r + CNT_W'(1)) == max_hits_r);
    cfg_ok_s   = (len_r != LEN_W'(0)) && (len_r <= LEN_W'(MAX_LEN)) &&
                 (max_hits_r != CNT_W'(0));
  end

  // Run-control FSM with shadow configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pattern_r   <= '0;
      len_r       <= LEN_W'(MAX_LEN);
      max_hits_r  <= CNT_W'(1);
      history_r   <= '0;
      fill_r      <= '0;
      hit_count_r <= '0;
      busy_r      <= 1'b0;
      match_r     <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else if (rst_sync_r) begin
      // Until the release is synchronized every register keeps its reset value.
      match_r   <= 1'b0;
      cfg_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (cfg_ok_s) begin
              state_r     <= RUN;
              busy_r      <= 1'b1;
              done_r      <= 1'b0;
              hit_count_r <= '0;
              fill_r      <= '0;
              history_r   <= '0;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
          if (cfg_we) begin
            pattern_r  <= cfg_pattern;
            len_r      <= cfg_len;
            max_hits_r <= cfg_max_hits;
          end
        end
        RUN: begin
          if (data_valid) begin
            history_r <= window_s[MAX_LEN-2:0];
            if (fill_r != LEN_W'(MAX_LEN)) begin
              fill_r <= fill_r + LEN_W'(1);
            end
          end
          if (hit_s) begin
            match_r     <= 1'b1;
            hit_count_r <= hit_count_r + CNT_W'(1);
          end
          // abort wins over completion, but a hit in this cycle still counts
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (last_hit_s) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          if (abort) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
          end else if (start) begin
            state_r     <= RUN;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            hit_count_r <= '0;
            fill_r      <= '0;
            history_r   <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign match     = match_r;
  assign hit_count = hit_count_r;
  assign done      = done_r;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against
// a queue-based behavioural model of the detector.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [CNT_W-1:0]   cfg_max_hits = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               data_valid = 1'b0;
  logic               data_in = 1'b0;
  logic               busy;
  logic               match;
  logic [CNT_W-1:0]   hit_count;
  logic               done;
  logic               cfg_err;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 run, 2 done
  int m_mode;
  int m_pat;
  int m_len;
  int m_max;
  int m_cnt;
  int exp_match;
  int exp_err;
  bit hist[$];

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_max_hits(cfg_max_hits), .start(start),
    .abort(abort), .data_valid(data_valid), .data_in(data_in),
    .busy(busy), .match(match), .hit_count(hit_count), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pat = 0; m_len = MAX_LEN; m_max = 1; m_cnt = 0;
    exp_match = 0; exp_err = 0;
    hist.delete();
  endtask

  // Advance the model by one clock using the current inputs.
  task automatic model_step();
    bit hit;
    bit ok;
    exp_match = 0;
    exp_err = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: begin
        ok = (m_len >= 1) && (m_len <= MAX_LEN) && (m_max != 0);
        if (start) begin
          if (ok) begin
            m_mode = 1; m_cnt = 0; hist.delete();
          end else begin
            exp_err = 1;
          end
        end
        if (cfg_we) begin
          m_pat = int'(cfg_pattern); m_len = int'(cfg_len); m_max = int'(cfg_max_hits);
        end
      end
      1: begin
        hit = 1'b0;
        if (data_valid) begin
          hist.push_back(data_in);
          if (hist.size() > MAX_LEN) void'(hist.pop_front());
          if (hist.size() >= m_len) begin
            hit = 1'b1;
            for (int k = 0; k < m_len; k++)
              if (hist[hist.size()-1-k] != m_pat[k]) hit = 1'b0;
          end
        end
        if (hit) begin
          m_cnt++;
          exp_match = 1;
        end
        if (abort) m_mode = 0;
        else if (hit && m_cnt == m_max) m_mode = 2;
      end
      default: begin
        if (abort) m_mode = 0;
        else if (start) begin
          m_mode = 1; m_cnt = 0; hist.delete();
        end
      end
    endcase
  endtask

  // One clock: update model, clock the DUT, compare all outputs.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("busy", busy, (m_mode == 1));
    chk("match", match, exp_match);
    chk("done", done, (m_mode == 2));
    chk("hit_count", hit_count, m_cnt);
    chk("cfg_err", cfg_err, exp_err);
  endtask

  task automatic configure(input int pat, input int len, input int mx);
    cfg_we = 1'b1;
    cfg_pattern = MAX_LEN'(pat);
    cfg_len = LEN_W'(len);
    cfg_max_hits = CNT_W'(mx);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // Send n bits msb-first; mvec[i] is the literal match expected after bit i.
  task automatic send_seq(input int bits, input int n, input int mvec);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data_in = bits[n-1-i];
      step();
      chk("lit_match", match, mvec[i]);
    end
    data_valid = 1'b0;
    data_in = 1'b0;
  endtask

  task automatic reset_release();
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_hit_count", hit_count, 0);
    reset_release();

    // single hit, len 7
    configure('h53, 7, 1);
    do_start();
    chk("t1_busy", busy, 1);
    send_seq('h53, 7, 'h40);
    chk("t1_count", hit_count, 1);
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);

    // overlapping hits, then bits ignored in DONE
    do_abort();
    chk("t2_abort_hold", hit_count, 1);
    configure('b101, 3, 3);
    do_start();
    send_seq('b1010101, 7, 'h54);
    chk("t2_done", done, 1);
    chk("t2_count", hit_count, 3);
    send_seq('b101, 3, 0);
    chk("t2_count_hold", hit_count, 3);

    // stall mid-pattern
    do_abort();
    configure('h53, 7, 1);
    do_start();
    send_seq('b101, 3, 0);
    repeat (4) begin
      step();
      chk("t3_stall_match", match, 0);
    end
    send_seq('b0011, 4, 'h8);
    chk("t3_done", done, 1);

    // configuration rejects
    do_abort();
    configure(5, 0, 1);
    do_start();
    chk("t4_err_len0", cfg_err, 1);
    chk("t4_busy", busy, 0);
    step();
    chk("t4_err_clear", cfg_err, 0);
    configure(5, 3, 0);
    do_start();
    chk("t4_err_max0", cfg_err, 1);
    configure(5, MAX_LEN + 1, 1);
    do_start();
    chk("t4_err_len_big", cfg_err, 1);

    // abort after 2 of 5 hits
    configure('b101, 3, 5);
    do_start();
    send_seq('b10101, 5, 'h14);
    do_abort();
    chk("t5_busy", busy, 0);
    chk("t5_count", hit_count, 2);
    chk("t5_done", done, 0);

    // cfg_we during RUN is ignored
    configure('b11, 2, 3);
    do_start();
    configure('b00, 2, 3);
    send_seq('b0011, 4, 'h8);
    chk("t6_count", hit_count, 1);

    // abort together with the final hit
    do_abort();
    configure('b11, 2, 1);
    do_start();
    send_seq('b1, 1, 0);
    data_valid = 1'b1; data_in = 1'b1; abort = 1'b1;
    step();
    data_valid = 1'b0; data_in = 1'b0; abort = 1'b0;
    chk("t7_match", match, 1);
    chk("t7_count", hit_count, 1);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);

    // reset mid-pattern, then default shadow configuration
    configure('b101, 3, 3);
    do_start();
    send_seq('b1010, 4, 'h4);
    rst_n = 1'b0;
    #1;
    chk("t8_busy", busy, 0);
    chk("t8_match", match, 0);
    chk("t8_done", done, 0);
    chk("t8_err", cfg_err, 0);
    chk("t8_count", hit_count, 0);
    step();
    reset_release();
    send_seq('b101, 3, 0);
    chk("t8_no_start", busy, 0);
    do_start();
    chk("t8_default_busy", busy, 1);
    send_seq(0, 8, 'h80);
    chk("t8_default_done", done, 1);

    // randomized traffic
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        cfg_we = 1'b0; start = 1'b0; abort = 1'b0; data_valid = 1'b0;
        step();
        reset_release();
      end
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_pattern = MAX_LEN'($urandom);
      cfg_len = LEN_W'($urandom_range(0, MAX_LEN + 1));
      cfg_max_hits = CNT_W'($urandom_range(0, 4));
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 49) == 0);
      data_valid = ($urandom_range(0, 4) != 0);
      data_in = $urandom_range(0, 1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
